// File: rtl/dcache_flush_ctrl.sv
// Data-cache flush sequencer: walks the tag array for line/dirty/clean flush
// commands, writes back dirty lines and rewrites valid/dirty bits.
module dcache_flush_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int SETS       = 64,
   parameter int WAYS       = 4,
   parameter int LINE_BYTES = 64,
   localparam int IDX_W     = $clog2(SETS),
   localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1,
   localparam int OFF_W     = $clog2(LINE_BYTES),
   localparam int TAG_W     = ADDR_W - IDX_W - OFF_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_req,
   input  logic [1:0]        flush_type,
   input  logic [ADDR_W-1:0] flush_addr,
   output logic              flush_ready,
   output logic              flush_busy,
   output logic              flush_done,
   output logic              tag_rd,
   output logic [IDX_W-1:0]  tag_idx,
   output logic [WAY_W-1:0]  tag_way,
   input  logic              tag_valid,
   input  logic              tag_dirty,
   input  logic [TAG_W-1:0]  tag_tag,
   output logic              tag_wr,
   output logic              tag_wr_valid,
   output logic              tag_wr_dirty,
   output logic              wb_req,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [IDX_W-1:0]  wb_idx,
   output logic [WAY_W-1:0]  wb_way,
   input  logic              wb_ack
);

   localparam logic [1:0] T_LINE  = 2'b00;
   localparam logic [1:0] T_DIRTY = 2'b01;
   localparam logic [1:0] T_RSVD  = 2'b11;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);
   localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

   typedef enum logic [2:0] {
      IDLE, READ, CHECK, WB, UPDATE, NEXT, DONE
   } state_t;

   state_t           state;
   logic [1:0]       type_r;
   logic [TAG_W-1:0] addr_tag;
   logic             upd_valid;
   logic             hit;
   logic             last_pos;
   logic             unused_off;

   assign unused_off = ^flush_addr[OFF_W-1:0];
   assign hit        = tag_valid && (tag_tag == addr_tag);
   assign last_pos   = (tag_way == LAST_WAY) && (type_r == T_LINE || tag_idx == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         type_r       <= 2'b00;
         addr_tag     <= '0;
         upd_valid    <= 1'b0;
         flush_ready  <= 1'b1;
         flush_busy   <= 1'b0;
         flush_done   <= 1'b0;
         tag_rd       <= 1'b0;
         tag_idx      <= '0;
         tag_way      <= '0;
         tag_wr       <= 1'b0;
         tag_wr_valid <= 1'b0;
         tag_wr_dirty <= 1'b0;
         wb_req       <= 1'b0;
         wb_addr      <= '0;
         wb_idx       <= '0;
         wb_way       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (flush_req) begin
                  type_r      <= flush_type;
                  addr_tag    <= flush_addr[ADDR_W-1 -: TAG_W];
                  tag_way     <= '0;
                  tag_idx     <= (flush_type == T_LINE) ? flush_addr[OFF_W +: IDX_W] : '0;
                  flush_ready <= 1'b0;
                  flush_busy  <= 1'b1;
                  if (flush_type == T_RSVD) begin
                     flush_done <= 1'b1;
                     state      <= DONE;
                  end else begin
                     tag_rd <= 1'b1;
                     state  <= READ;
                  end
               end
            end
            READ: begin
               tag_rd <= 1'b0;
               state  <= CHECK;
            end
            CHECK: begin
               // Line mode only acts on a tag hit; dirty/clean modes act on any valid line.
               upd_valid <= (type_r == T_DIRTY);
               if (tag_dirty && (type_r == T_LINE ? hit : tag_valid)) begin
                  wb_req  <= 1'b1;
                  wb_addr <= {tag_tag, tag_idx, {OFF_W{1'b0}}};
                  wb_idx  <= tag_idx;
                  wb_way  <= tag_way;
                  state   <= WB;
               end else if (type_r != T_DIRTY && (type_r == T_LINE ? hit : tag_valid)) begin
                  tag_wr       <= 1'b1;
                  tag_wr_valid <= 1'b0;
                  tag_wr_dirty <= 1'b0;
                  state        <= UPDATE;
               end else begin
                  state <= NEXT;
               end
            end
            WB: begin
               if (wb_ack) begin
                  wb_req       <= 1'b0;
                  tag_wr       <= 1'b1;
                  tag_wr_valid <= upd_valid;
                  tag_wr_dirty <= 1'b0;
                  state        <= UPDATE;
               end
            end
            UPDATE: begin
               tag_wr       <= 1'b0;
               tag_wr_valid <= 1'b0;
               if (type_r == T_LINE) begin
                  flush_done <= 1'b1;
                  state      <= DONE;
               end else begin
                  state <= NEXT;
               end
            end
            NEXT: begin
               if (tag_way == LAST_WAY) begin
                  tag_way <= '0;
                  tag_idx <= tag_idx + 1'b1;
               end else begin
                  tag_way <= tag_way + 1'b1;
               end
               if (last_pos) begin
                  flush_done <= 1'b1;
                  state      <= DONE;
               end else begin
                  tag_rd <= 1'b1;
                  state  <= READ;
               end
            end
            DONE: begin
               flush_done  <= 1'b0;
               flush_busy  <= 1'b0;
               flush_ready <= 1'b1;
               tag_idx     <= '0;
               tag_way     <= '0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Directed bench for dcache_flush_ctrl with a small tag-array model and an
// auto-acknowledging writeback responder.
module tb_dcache_flush_ctrl;
   localparam int ADDR_W = 32, SETS = 4, WAYS = 2, LINE_BYTES = 16;
   localparam int IDX_W = 2, WAY_W = 1, OFF_W = 4, TAG_W = ADDR_W - IDX_W - OFF_W;
   localparam int N = SETS * WAYS;

   logic clk = 0, rst_n = 0;
   logic flush_req = 0;
   logic [1:0] flush_type = 0;
   logic [ADDR_W-1:0] flush_addr = 0;
   logic flush_ready, flush_busy, flush_done, tag_rd, tag_wr, tag_wr_valid, tag_wr_dirty;
   logic [IDX_W-1:0] tag_idx, wb_idx;
   logic [WAY_W-1:0] tag_way, wb_way;
   logic tag_valid = 0, tag_dirty = 0;
   logic [TAG_W-1:0] tag_tag = 0;
   logic wb_req, wb_ack;
   logic [ADDR_W-1:0] wb_addr;
   logic auto_ack = 0, force_ack = 0, ack_en = 0;
   int ack_delay = 3, wbc = 0;

   logic mv [N], md [N];
   logic [TAG_W-1:0] mt [N];

   int rd_cnt, wr_cnt, wbreq_cnt, wb_addr_bad, last_wr_idx, last_wr_way, last_wr_v, last_wr_d;
   logic [ADDR_W-1:0] wb_addr_first;
   int wb_idx_first, wb_way_first;
   int pass_cnt = 0, total_cnt = 0;

   assign wb_ack = auto_ack | force_ack;

   dcache_flush_ctrl #(.ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS), .LINE_BYTES(LINE_BYTES)) dut (
      .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .flush_type(flush_type),
      .flush_addr(flush_addr), .flush_ready(flush_ready), .flush_busy(flush_busy),
      .flush_done(flush_done), .tag_rd(tag_rd), .tag_idx(tag_idx), .tag_way(tag_way),
      .tag_valid(tag_valid), .tag_dirty(tag_dirty), .tag_tag(tag_tag), .tag_wr(tag_wr),
      .tag_wr_valid(tag_wr_valid), .tag_wr_dirty(tag_wr_dirty), .wb_req(wb_req),
      .wb_addr(wb_addr), .wb_idx(wb_idx), .wb_way(wb_way), .wb_ack(wb_ack)
   );

   always #5 clk = ~clk;

   // Tag array: one-cycle read latency, write on strobe.
   always @(posedge clk) begin
      if (tag_rd) begin
         tag_valid <= mv[tag_idx*WAYS + tag_way];
         tag_dirty <= md[tag_idx*WAYS + tag_way];
         tag_tag   <= mt[tag_idx*WAYS + tag_way];
      end
      if (tag_wr) begin
         mv[tag_idx*WAYS + tag_way] <= tag_wr_valid;
         md[tag_idx*WAYS + tag_way] <= tag_wr_dirty;
      end
   end

   always @(negedge clk) begin
      if (tag_rd) rd_cnt++;
      if (tag_wr) begin
         wr_cnt++;
         last_wr_idx = tag_idx; last_wr_way = tag_way;
         last_wr_v = tag_wr_valid; last_wr_d = tag_wr_dirty;
      end
      if (wb_req) begin
         if (wbreq_cnt == 0) begin
            wb_addr_first = wb_addr; wb_idx_first = wb_idx; wb_way_first = wb_way;
         end else if (wb_addr != wb_addr_first) wb_addr_bad++;
         wbreq_cnt++;
      end
      if (wb_req && ack_en) begin
         wbc++;
         auto_ack = (wbc >= ack_delay);
      end else begin
         wbc = 0;
         auto_ack = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic clear_stats();
      rd_cnt = 0; wr_cnt = 0; wbreq_cnt = 0; wb_addr_bad = 0;
      last_wr_idx = -1; last_wr_way = -1; last_wr_v = -1; last_wr_d = -1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < N; i++) begin mv[i] = 0; md[i] = 0; mt[i] = '0; end
   endtask

   // Issue one command; cyc = 1 + edges after the accept edge until flush_done.
   task automatic run_cmd(input logic [1:0] t, input logic [ADDR_W-1:0] a, output int cyc);
      int e;
      @(negedge clk);
      flush_req = 1; flush_type = t; flush_addr = a;
      @(posedge clk); #1;
      flush_req = 0;
      e = 0;
      while (!flush_done && e < 500) begin
         @(posedge clk); #1;
         e++;
      end
      if (e >= 500) check("done_timeout", 0, 1);
      cyc = e + 1;
      @(posedge clk); #1;
   endtask

   initial begin
      int cyc, gap, viol, e;
      clear_mem();
      clear_stats();
      #12;
      check("rst_ready", flush_ready, 1);
      check("rst_busy", flush_busy, 0);
      check("rst_wb_req", wb_req, 0);
      check("rst_tag_wr", tag_wr, 0);
      check("rst_done", flush_done, 0);
      @(negedge clk); rst_n = 1;
      repeat (2) @(negedge clk);

      // Clean walk over an empty cache
      clear_stats();
      run_cmd(2'b10, 32'h0, cyc);
      check("clean_cyc", cyc, 25);
      check("clean_rd", rd_cnt, 8);
      check("clean_wr", wr_cnt, 0);
      check("clean_ready", flush_ready, 1);

      // Dirty mode, one dirty line at set 2 / way 1
      clear_mem(); clear_stats();
      mv[5] = 1; md[5] = 1; mt[5] = 26'h48D0;
      ack_en = 1; ack_delay = 3;
      run_cmd(2'b01, 32'h0, cyc);
      check("dirty_cyc", cyc, 29);
      check("dirty_wbreq_cycles", wbreq_cnt, 3);
      check("dirty_wb_addr", wb_addr_first, 32'h00123420);
      check("dirty_wb_addr_stable", wb_addr_bad, 0);
      check("dirty_wb_idx", wb_idx_first, 2);
      check("dirty_wb_way", wb_way_first, 1);
      check("dirty_wr_cnt", wr_cnt, 1);
      check("dirty_wr_idx", last_wr_idx, 2);
      check("dirty_wr_way", last_wr_way, 1);
      check("dirty_wr_valid", last_wr_v, 1);
      check("dirty_wr_dirty", last_wr_d, 0);
      check("dirty_mem_d", md[5], 0);

      // Line mode hit on a clean line at set 1 / way 0
      clear_mem(); clear_stats();
      mv[2] = 1; md[2] = 0; mt[2] = 26'h2AF34;
      run_cmd(2'b00, 32'h00ABCD10, cyc);
      check("line_cyc", cyc, 4);
      check("line_wr_cnt", wr_cnt, 1);
      check("line_wr_idx", last_wr_idx, 1);
      check("line_wr_way", last_wr_way, 0);
      check("line_wr_valid", last_wr_v, 0);
      check("line_wr_dirty", last_wr_d, 0);
      check("line_wbreq", wbreq_cnt, 0);
      check("line_mem_v", mv[2], 0);

      // Line mode miss
      clear_stats();
      run_cmd(2'b00, 32'h00ABCD10, cyc);
      check("miss_cyc", cyc, 7);
      check("miss_rd", rd_cnt, 2);
      check("miss_wr", wr_cnt, 0);

      // Reserved type
      clear_stats();
      run_cmd(2'b11, 32'h0, cyc);
      check("rsvd_cyc", cyc, 1);
      check("rsvd_rd", rd_cnt, 0);

      // Request held high during a busy walk
      clear_mem(); clear_stats();
      @(negedge clk);
      flush_req = 1; flush_type = 2'b10;
      @(posedge clk); #1;
      flush_type = 2'b11;
      e = 0; viol = 0;
      while (!flush_done && e < 500) begin
         if (flush_ready) viol++;
         @(posedge clk); #1; e++;
      end
      check("busy_first_cyc", e + 1, 25);
      gap = 0;
      do begin @(posedge clk); #1; gap++; end while (!flush_done && gap < 10);
      flush_req = 0;
      check("busy_no_accept", viol, 0);
      check("busy_b2b_gap", gap, 2);
      check("busy_rd", rd_cnt, 8);
      repeat (2) @(posedge clk);

      // Reset asserted in the middle of a writeback
      clear_mem(); clear_stats();
      mv[0] = 1; md[0] = 1; mt[0] = 26'h1;
      ack_en = 0;
      @(negedge clk);
      flush_req = 1; flush_type = 2'b01;
      @(posedge clk); #1;
      flush_req = 0;
      e = 0;
      while (!wb_req && e < 20) begin @(posedge clk); #1; e++; end
      check("rstwb_reached_wb", wb_req, 1);
      @(posedge clk); #3;
      rst_n = 0;
      #1;
      check("rstwb_wb_req", wb_req, 0);
      check("rstwb_busy", flush_busy, 0);
      check("rstwb_ready", flush_ready, 1);
      @(negedge clk); rst_n = 1;
      force_ack = 1;
      @(negedge clk); force_ack = 0;
      repeat (3) @(negedge clk);
      check("rstwb_no_wr", wr_cnt, 0);
      check("rstwb_idle", flush_busy, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1);
   end
endmodule
